// File: rtl/switch_ingress_router.sv
// switch_ingress_router: parses DA/SA/LEN packets from one link and writes every byte to the FIFO chosen by DA.
// Define ROUTER_BCAST_EN to send DA all-ones to every port at once.
module switch_ingress_router #(
    parameter int W_WIDTH = 8,
    parameter int N_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [W_WIDTH-1:0]           in_data,
    output logic                         in_ready,
    input  logic [N_PORTS*W_WIDTH-1:0]   port_addr,
    input  logic [N_PORTS-1:0]           fifo_full,
    output logic [N_PORTS-1:0]           fifo_wr_en,
    output logic [W_WIDTH-1:0]           fifo_data,
    output logic [15:0]                  pkt_cnt,
    output logic [15:0]                  drop_cnt
);
    typedef enum logic [1:0] {IDLE, SA, LEN, PAYLOAD} state_t;
    state_t state;
    logic [W_WIDTH-1:0] remain;
    logic [N_PORTS-1:0] mask, dec_mask, eff_mask;
    logic drop, accept;

    // Scanning downward lets the lowest matching port win.
    always_comb begin
        dec_mask = '0;
        for (int p = N_PORTS - 1; p >= 0; p--)
            if (in_data == port_addr[p*W_WIDTH +: W_WIDTH]) dec_mask = N_PORTS'(1) << p;
`ifdef ROUTER_BCAST_EN
        if (&in_data) dec_mask = '1;
`endif
    end

    always_comb begin
        eff_mask   = (state == IDLE) ? dec_mask : (drop ? '0 : mask);
        in_ready   = ~|(eff_mask & fifo_full);
        accept     = in_valid && in_ready;
        fifo_wr_en = accept ? eff_mask : '0;
        fifo_data  = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            remain   <= '0;
            mask     <= '0;
            drop     <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    state <= SA;
                    mask  <= dec_mask;
                    drop  <= ~|dec_mask;
                    if (~|dec_mask) drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
                    else            pkt_cnt  <= pkt_cnt + 16'(pkt_cnt != 16'hFFFF);
                end
                SA: state <= LEN;
                LEN: begin
                    remain <= in_data;
                    state  <= (in_data == '0) ? IDLE : PAYLOAD;
                end
                PAYLOAD: begin
                    remain <= remain - 1'b1;
                    if (remain == W_WIDTH'(1)) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_switch_ingress_router.sv
// tb_switch_ingress_router: packet-level model checked every cycle, plus directed literal checks.
module tb_switch_ingress_router;
    logic        clk = 0, rst_n = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready;
    logic [31:0] port_addr = {8'h40, 8'h30, 8'h20, 8'h10};
    logic [3:0]  fifo_full = 0, fifo_wr_en;
    logic [7:0]  fifo_data;
    logic [15:0] pkt_cnt, drop_cnt;
    int tests = 0, fails = 0, stall_cycles = 0;
    logic [7:0] q[4][$];
    int pos = 0, len = 0, m_pkt = 0, m_drop = 0;
    logic [3:0] cur = 0;

    always #5 clk = ~clk;

    switch_ingress_router #(.W_WIDTH(8), .N_PORTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .port_addr(port_addr), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    function automatic logic [3:0] route(logic [7:0] d);
`ifdef ROUTER_BCAST_EN
        if (d == 8'hFF) return 4'hF;
`endif
        for (int p = 0; p < 4; p++)
            if (d == port_addr[p*8 +: 8]) return 4'(1 << p);
        return 4'h0;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkq(string name, int p, logic [7:0] e[$]);
        chk({name, "_len"}, q[p].size(), e.size());
        for (int i = 0; i < e.size() && i < q[p].size(); i++) chk({name, "_byte"}, q[p][i], e[i]);
    endtask

    task automatic clrq();
        for (int p = 0; p < 4; p++) q[p].delete();
    endtask

    // Model: byte position within the packet decides header vs payload; DA picks the target.
    always @(negedge clk) begin
        logic [3:0] tgt, ewr;
        logic erdy;
        if (!rst_n) begin
            pos = 0; len = 0; cur = 0; m_pkt = 0; m_drop = 0;
            chk("rst_wr_en", fifo_wr_en, 0);
            chk("rst_pkt_cnt", pkt_cnt, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
            if (!in_valid) chk("rst_in_ready", in_ready, 1);
        end else begin
            tgt  = (pos == 0) ? route(in_data) : cur;
            erdy = (tgt & fifo_full) == 0;
            ewr  = (in_valid && erdy) ? tgt : 4'h0;
            chk("in_ready", in_ready, erdy);
            chk("fifo_wr_en", fifo_wr_en, ewr);
            chk("pkt_cnt", pkt_cnt, m_pkt);
            chk("drop_cnt", drop_cnt, m_drop);
            if (ewr != 0) chk("fifo_data", fifo_data, in_data);
            if (in_valid && !in_ready) stall_cycles++;
            for (int p = 0; p < 4; p++) if (fifo_wr_en[p]) q[p].push_back(fifo_data);
            if (in_valid && erdy) begin
                if (pos == 0) begin
                    cur = tgt;
                    if (tgt != 0) m_pkt = (m_pkt < 65535) ? m_pkt + 1 : m_pkt;
                    else m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
                end
                if (pos == 2) len = in_data;
                pos++;
                if (pos >= 3 && pos == len + 3) pos = 0;
            end
        end
    end

    task automatic send(logic [7:0] b);
        int n = 0;
        in_valid = 1; in_data = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic stall(logic [3:0] f, int cycles);
        fifo_full = f;
        fork begin repeat (cycles) @(posedge clk); #1 fifo_full = 0; end join_none
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk); #1 rst_n = 1;
        clrq();
        send(8'h20); send(8'h01); send(8'h03); send(8'hA1); send(8'hA2); send(8'hA3);
        chkq("unicast_p1", 1, {8'h20, 8'h01, 8'h03, 8'hA1, 8'hA2, 8'hA3});
        chk("unicast_others", q[0].size() + q[2].size() + q[3].size(), 0);
        chk("unicast_pkt_cnt", pkt_cnt, 1);
        clrq();
        send(8'h55); send(8'h02); send(8'h02); send(8'hB1); send(8'hB2);
        chk("drop_writes", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        chk("drop_cnt_lit", drop_cnt, 1);
        stall_cycles = 0;
        send(8'h30); send(8'h05); send(8'h04); send(8'hC1);
        stall(4'b0100, 4);
        send(8'hC2); send(8'hC3); send(8'hC4);
        chk("stall_cycles", stall_cycles, 4);
        chkq("stall_p2", 2, {8'h30, 8'h05, 8'h04, 8'hC1, 8'hC2, 8'hC3, 8'hC4});
        chk("stall_pkt_cnt", pkt_cnt, 2);
        clrq();
        send(8'h10); send(8'h07); send(8'h00);
        send(8'h20); send(8'h08); send(8'h01); send(8'hD1);
        chkq("len0_p0", 0, {8'h10, 8'h07, 8'h00});
        chkq("b2b_p1", 1, {8'h20, 8'h08, 8'h01, 8'hD1});
        chk("b2b_pkt_cnt", pkt_cnt, 4);
        send(8'h30); send(8'h09); send(8'h05); send(8'hE1); send(8'hE2);
        rst_n = 0;
        repeat (2) @(posedge clk); #1 rst_n = 1;
        chk("post_rst_pkt_cnt", pkt_cnt, 0);
        chk("post_rst_drop_cnt", drop_cnt, 0);
        clrq();
        send(8'h40); send(8'h0A); send(8'h01); send(8'hF1);
        chkq("post_rst_p3", 3, {8'h40, 8'h0A, 8'h01, 8'hF1});
        chk("post_rst_pkt_one", pkt_cnt, 1);
        clrq();
        stall_cycles = 0;
`ifdef ROUTER_BCAST_EN
        send(8'hFF); send(8'h0B); send(8'h01);
        stall(4'b0001, 3);
        send(8'hD7);
        for (int p = 0; p < 4; p++) chkq("bcast", p, {8'hFF, 8'h0B, 8'h01, 8'hD7});
        chk("bcast_stall", stall_cycles, 3);
        chk("bcast_pkt_cnt", pkt_cnt, 2);
`else
        send(8'hFF); send(8'h0C); send(8'h00);
        chk("ff_writes", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        chk("ff_drop_cnt", drop_cnt, 1);
`endif
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
